// File: rtl/vga_pkg.sv
// Default 640x480@60 Hz timing constants and the timing FSM state type
// shared by the VGA timing generator.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous level input.
// Both flops clear to 0 under reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample the old values on
  // the same edge, giving a true two-stage pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel timing generator: x/y counters plus registered sync, active-video and
// strobe decode, held idle until the synchronized PLL lock flag is high.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  import vga_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             locked_s;
  state_t           state, state_nxt;
  logic             run_nxt;
  logic [CNT_W-1:0] x_nxt, y_nxt;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOCK: if (locked_s)  state_nxt = RUN;
      RUN:       if (!locked_s) state_nxt = WAIT_LOCK;
      default:                  state_nxt = WAIT_LOCK;
    endcase
  end

  assign run_nxt = (state_nxt == RUN);

  // Counters restart at (0,0) on entry to RUN and are held at 0 while idle.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    if (run_nxt && state == RUN) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
        y_nxt = y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

  // Decode from the next counter values so the registered flags line up with
  // the x,y presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !(run_nxt && x_nxt >= HS_BEGIN && x_nxt < HS_END);
      vsync       <= !(run_nxt && y_nxt >= VS_BEGIN && y_nxt < VS_END);
      de          <= run_nxt && x_nxt < X_ACT && y_nxt < Y_ACT;
      line_start  <= run_nxt && x_nxt == '0;
      frame_start <= run_nxt && x_nxt == '0 && y_nxt == '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a per-edge scoreboard of expected
// outputs plus directed checks of lock, line, frame and reset behaviour.
module tb_vga_timing_gen;

  localparam int CNT_W    = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  // Short frame keeps a full-frame run well inside the cycle budget.
  localparam int V_ACTIVE = 30;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;
  localparam int NEVER    = 32'h7fff_ffff;

  logic             clk;
  logic             rst_n;
  logic             locked;
  logic             hsync, vsync, de, line_start, frame_start;
  logic [CNT_W-1:0] x, y;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
  } obs_t;

  obs_t sb_q[$];
  int   checks       = 0;
  int   failures     = 0;
  int   edge_n       = 0;
  int   active_start = NEVER;
  int   active_stop  = NEVER;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .locked      (locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic obs_t idle_obs();
    obs_t r;
    r       = '0;
    r.hsync = 1'b1;
    r.vsync = 1'b1;
    return r;
  endfunction

  // Expected outputs t cycles after the run started at (0,0).
  function automatic obs_t expect_at(int t);
    obs_t r;
    int   xi, yi;
    xi            = t % HT;
    yi            = (t / HT) % VT;
    r.x           = CNT_W'(xi);
    r.y           = CNT_W'(yi);
    r.hsync       = !(xi >= H_ACTIVE + H_FP && xi < H_ACTIVE + H_FP + H_SYNC);
    r.vsync       = !(yi >= V_ACTIVE + V_FP && yi < V_ACTIVE + V_FP + V_SYNC);
    r.de          = (xi < H_ACTIVE) && (yi < V_ACTIVE);
    r.line_start  = (xi == 0);
    r.frame_start = (xi == 0) && (yi == 0);
    return r;
  endfunction

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!rst_n || edge_n < active_start || edge_n >= active_stop)
      sb_q.push_back(idle_obs());
    else
      sb_q.push_back(expect_at(edge_n - active_start));
  end

  always @(negedge clk) begin : sb_check
    obs_t e;
    obs_t o;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = {hsync, vsync, de, x, y, line_start, frame_start};
      checks = checks + 1;
      assert (o === e) else begin
        failures = failures + 1;
        $error("FAIL sb edge=%0d observed=%p expected=%p", edge_n, o, e);
      end
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int hs_lo, de_hi, vs_lo, fs_cnt, de_bad, cur, target;
    logic vs_prev, wrap_next, wrap_seen;

    rst_n  = 1'b0;
    locked = 1'b1;
    tick(3);
    check("reset_hsync", int'(hsync), 1);
    check("reset_vsync", int'(vsync), 1);
    check("reset_de",    int'(de), 0);
    check("reset_x",     int'(x), 0);
    check("reset_y",     int'(y), 0);
    check("reset_ls",    int'(line_start), 0);
    check("reset_fs",    int'(frame_start), 0);

    // Lock acquire: outputs go live on the third edge after reset release.
    rst_n        = 1'b1;
    active_start = edge_n + 3;
    tick(2);
    check("prelock_de", int'(de), 0);
    check("prelock_fs", int'(frame_start), 0);
    tick(1);
    check("lock_fs", int'(frame_start), 1);
    check("lock_ls", int'(line_start), 1);
    check("lock_de", int'(de), 1);
    check("lock_x",  int'(x), 0);
    check("lock_y",  int'(y), 0);

    // Two full lines.
    hs_lo = 0;
    de_hi = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      if (!hsync) hs_lo++;
      if (de) de_hi++;
      if (i == HT) begin
        check("wrap_x",  int'(x), 0);
        check("wrap_y",  int'(y), 1);
        check("wrap_ls", int'(line_start), 1);
      end
      tick(1);
    end
    check("line_hsync_low", hs_lo, 2 * H_SYNC);
    check("line_de_high",   de_hi, 2 * H_ACTIVE);

    // One full frame period.
    vs_lo     = 0;
    de_hi     = 0;
    fs_cnt    = 0;
    de_bad    = 0;
    vs_prev   = 1'b1;
    wrap_next = 1'b0;
    wrap_seen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (!vsync) vs_lo++;
      if (de) de_hi++;
      if (frame_start) fs_cnt++;
      if (de && y >= CNT_W'(V_ACTIVE)) de_bad++;
      if (vs_prev && !vsync) begin
        check("vs_fall_x",  int'(x), 0);
        check("vs_fall_y",  int'(y), V_ACTIVE + V_FP);
        check("vs_fall_ls", int'(line_start), 1);
      end
      if (wrap_next) begin
        check("frame_wrap_x",  int'(x), 0);
        check("frame_wrap_y",  int'(y), 0);
        check("frame_wrap_fs", int'(frame_start), 1);
        wrap_next = 1'b0;
        wrap_seen = 1'b1;
      end
      if (x == CNT_W'(HT - 1) && y == CNT_W'(VT - 1)) wrap_next = 1'b1;
      vs_prev = vsync;
      tick(1);
    end
    check("frame_vsync_low",  vs_lo, V_SYNC * HT);
    check("frame_de_high",    de_hi, H_ACTIVE * V_ACTIVE);
    check("frame_fs_count",   fs_cnt, 1);
    check("frame_de_blank",   de_bad, 0);
    check("frame_wrap_seen",  int'(wrap_seen), 1);

    // Lock loss at (300,5).
    target = 5 * HT + 300;
    cur    = (edge_n - active_start) % FRAME;
    tick((target - cur + FRAME) % FRAME);
    check("loss_at_x", int'(x), 300);
    check("loss_at_y", int'(y), 5);
    locked      = 1'b0;
    active_stop = edge_n + 3;
    tick(2);
    check("loss_still_run_x", int'(x), 302);
    tick(1);
    check("loss_idle_hsync", int'(hsync), 1);
    check("loss_idle_de",    int'(de), 0);
    check("loss_idle_x",     int'(x), 0);
    check("loss_idle_y",     int'(y), 0);
    tick(20);
    check("loss_hold_x",  int'(x), 0);
    check("loss_hold_de", int'(de), 0);

    // Regain lock: restart from (0,0).
    locked       = 1'b1;
    active_start = edge_n + 3;
    active_stop  = NEVER;
    tick(3);
    check("relock_fs", int'(frame_start), 1);
    check("relock_x",  int'(x), 0);
    check("relock_y",  int'(y), 0);
    check("relock_de", int'(de), 1);

    // Async reset mid-line while hsync is low.
    tick(700);
    check("pre_rst_x",     int'(x), 700);
    check("pre_rst_hsync", int'(hsync), 0);
    rst_n        = 1'b0;
    active_start = NEVER;
    #1;
    check("async_rst_hsync", int'(hsync), 1);
    check("async_rst_x",     int'(x), 0);
    check("async_rst_y",     int'(y), 0);
    check("async_rst_de",    int'(de), 0);
    tick(3);
    rst_n        = 1'b1;
    active_start = edge_n + 3;
    tick(3);
    check("rst_relock_fs", int'(frame_start), 1);
    check("rst_relock_x",  int'(x), 0);
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
